// File: rtl/cpu_pkg.sv
// Shared processor definitions: default PC width, reset vector and the
// per-cycle decision codes used by the PC / return-stack stage.
package cpu_pkg;

    localparam int unsigned CPU_PC_WIDTH = 10;
    localparam logic [CPU_PC_WIDTH-1:0] PC_RESET = '0;

    typedef enum logic [2:0] {
        OP_SEQ       = 3'd0,
        OP_ILLEGAL   = 3'd1,
        OP_POP       = 3'd2,
        OP_UNDERFLOW = 3'd3,
        OP_PUSH      = 3'd4,
        OP_OVERFLOW  = 3'd5
    } pc_op_e;

    // Priority order matters: an illegal push+pop beats everything, and
    // a return is resolved before a call.
    function automatic pc_op_e decode_op(input logic wesp,
                                         input logic push,
                                         input logic pop,
                                         input logic full,
                                         input logic empty);
        pc_op_e op;
        op = OP_SEQ;
        if (wesp) begin
            if (push && pop)   op = OP_ILLEGAL;
            else if (pop)      op = empty ? OP_UNDERFLOW : OP_POP;
            else if (push)     op = full ? OP_OVERFLOW : OP_PUSH;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control-unit <-> PC stage signal bundle: sequencing strobes in, PC and
// return-stack status out.
interface pc_stack_if
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int STACK_DEPTH = 8
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                s_inc;
    logic                wesp;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] jump_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [SP_WIDTH-1:0] sp;
    logic                stack_full;
    logic                stack_empty;
    logic                stack_err;

    modport master (
        output s_inc, wesp, push, pop, jump_addr,
        input  pc, sp, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  s_inc, wesp, push, pop, jump_addr,
        output pc, sp, stack_full, stack_empty, stack_err
    );

endinterface

// File: rtl/pc_stack_ret_stack.sv
// Register-file LIFO holding return addresses. Only the stack pointer is
// reset; entry contents are left uninitialised since they are never read above sp.
module ret_stack #(
    parameter int DATA_WIDTH  = 10,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_en,
    input  logic                  pop_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] top,
    output logic [SP_WIDTH-1:0]   sp,
    output logic                  full,
    output logic                  empty
);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SP_WIDTH-1:0]   sp_q, sp_d;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (sp_q == SP_WIDTH'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign do_push = push_en && !full;
    assign do_pop  = pop_en && !empty;
    assign wr_idx  = sp_q[IDX_W-1:0];
    assign rd_idx  = IDX_W'(sp_q - SP_WIDTH'(1));
    assign top     = mem_q[rd_idx];
    assign sp      = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (do_push)     sp_d = sp_q + SP_WIDTH'(1);
        else if (do_pop) sp_d = sp_q - SP_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= wdata;
    end

endmodule

// File: rtl/pc_stack.sv
// Program-counter stage: registered PC, next-PC select (increment, jump,
// call, return) and the sticky stack-error flag around a ret_stack LIFO.
module pc_stack
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    pc_stack_if.slave   bus
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] stk_top;
    logic [SP_WIDTH-1:0] stk_sp;
    logic                stk_full;
    logic                stk_empty;
    logic                err_q, err_d;
    logic                push_en;
    logic                pop_en;
    pc_op_e              op;

    // Wraps modulo 2^PC_WIDTH; also the return address saved by a call.
    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign op     = decode_op(bus.wesp, bus.push, bus.pop, stk_full, stk_empty);

    always_comb begin
        pc_d    = pc_inc;
        err_d   = err_q;
        push_en = 1'b0;
        pop_en  = 1'b0;
        unique case (op)
            OP_SEQ:       pc_d = bus.s_inc ? pc_inc : bus.jump_addr;
            OP_POP: begin
                pc_d   = stk_top;
                pop_en = 1'b1;
            end
            OP_PUSH: begin
                pc_d    = bus.jump_addr;
                push_en = 1'b1;
            end
            OP_ILLEGAL, OP_UNDERFLOW, OP_OVERFLOW: err_d = 1'b1;
            default:      pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= PC_WIDTH'(PC_RESET);
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    ret_stack #(
        .DATA_WIDTH  (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH),
        .SP_WIDTH    (SP_WIDTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset   (reset),
        .push_en (push_en),
        .pop_en  (pop_en),
        .wdata   (pc_inc),
        .top     (stk_top),
        .sp      (stk_sp),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    assign bus.pc          = pc_q;
    assign bus.sp          = stk_sp;
    assign bus.stack_full  = stk_full;
    assign bus.stack_empty = stk_empty;
    assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: sequencing, jump, call/return, stack
// overflow/underflow, illegal op, PC wrap and asynchronous reset.
module tb_pc_stack;
    localparam int PC_WIDTH    = 10;
    localparam int STACK_DEPTH = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [9:0] exp_pc;
    logic [9:0] ret_addr [8];

    pc_stack_if #(.PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH)) ifc ();

    pc_stack #(.PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [9:0] pc_e,
                               input logic [3:0] sp_e, input logic err_e);
        check({tag, ".pc"},    32'(ifc.pc),          32'(pc_e));
        check({tag, ".sp"},    32'(ifc.sp),          32'(sp_e));
        check({tag, ".err"},   32'(ifc.stack_err),   32'(err_e));
        check({tag, ".full"},  32'(ifc.stack_full),  32'(sp_e == 4'd8));
        check({tag, ".empty"}, 32'(ifc.stack_empty), 32'(sp_e == 4'd0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic s_inc, input logic wesp, input logic push,
                           input logic pop, input logic [9:0] jaddr);
        ifc.s_inc     = s_inc;
        ifc.wesp      = wesp;
        ifc.push      = push;
        ifc.pop       = pop;
        ifc.jump_addr = jaddr;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        #1;
        check_state("reset_async", 10'h000, 4'd0, 1'b0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);

        // Power-on reset and sequential walk.
        do_reset();
        check_state("reset", 10'h000, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_state("seq", 10'(i), 4'd0, 1'b0);
        end

        // Plain jump, then a jump with push/pop strobes but wesp low.
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 10'h120);
        tick();
        check_state("jump", 10'h120, 4'd0, 1'b0);
        strobes(1'b1, 1'b0, 1'b1, 1'b0, 10'h2AA);
        tick();
        check_state("push_no_wesp", 10'h121, 4'd0, 1'b0);
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 10'h010);
        tick();
        check_state("jump_010", 10'h010, 4'd0, 1'b0);

        // Call then immediate return.
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 10'h200);
        tick();
        check_state("call", 10'h200, 4'd1, 1'b0);
        strobes(1'b0, 1'b1, 1'b0, 1'b1, 10'h3CC);
        tick();
        check_state("ret", 10'h011, 4'd0, 1'b0);

        // Eight nested calls fill the stack.
        exp_pc = 10'h011;
        for (int k = 0; k < 8; k++) begin
            ret_addr[k] = exp_pc + 10'd1;
            exp_pc      = 10'h100 + 10'(k * 16);
            strobes(1'b0, 1'b1, 1'b1, 1'b0, exp_pc);
            tick();
            check_state("nest_call", exp_pc, 4'(k + 1), 1'b0);
        end
        // Ninth call overflows: suppressed, pc increments, error latches.
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 10'h3AA);
        tick();
        check_state("overflow", 10'h171, 4'd8, 1'b1);
        for (int k = 7; k >= 0; k--) begin
            strobes(1'b1, 1'b1, 1'b0, 1'b1, 10'h000);
            tick();
            check_state("nest_ret", ret_addr[k], 4'(k), 1'b1);
        end
        check("ret_order_first", 32'(ret_addr[0]), 32'h012);

        // Underflow at pc=5.
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check_state("pre_underflow", 10'h005, 4'd0, 1'b0);
        strobes(1'b0, 1'b1, 1'b0, 1'b1, 10'h1FF);
        tick();
        check_state("underflow", 10'h006, 4'd0, 1'b1);
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        check_state("err_sticky", 10'h007, 4'd0, 1'b1);

        // Illegal push+pop at pc=5.
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        strobes(1'b0, 1'b1, 1'b1, 1'b1, 10'h1FF);
        tick();
        check_state("illegal", 10'h006, 4'd0, 1'b1);
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        check_state("illegal_sticky", 10'h007, 4'd0, 1'b1);

        // PC wrap and call from the last address.
        do_reset();
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF);
        tick();
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        check_state("wrap", 10'h000, 4'd0, 1'b0);
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF);
        tick();
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 10'h055);
        tick();
        check_state("call_3ff", 10'h055, 4'd1, 1'b0);
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 10'h066);
        tick();
        check_state("call_055", 10'h066, 4'd2, 1'b0);
        strobes(1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        tick();
        check_state("ret_to_056", 10'h056, 4'd1, 1'b0);
        tick();
        check_state("ret_wrapped", 10'h000, 4'd0, 1'b0);

        // Reset mid-call: outputs clear without a clock edge.
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 10'h2BC);
        tick();
        check_state("pre_mid_reset", 10'h2BC, 4'd1, 1'b0);
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 10'h3BC);
        #2;
        reset = 1'b0;
        #1;
        check_state("mid_reset", 10'h000, 4'd0, 1'b0);
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        reset = 1'b1;
        check_state("held_reset", 10'h000, 4'd0, 1'b0);
        tick();
        check_state("after_reset", 10'h001, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
